// File: rtl/ahb_slv_pkg.sv
// ---------------------------------------------------------------------------
// ahb_slv_pkg
// Shared types and helpers for the AHB-lite SRAM slave.
//   htrans_e    : AHB transfer type encoding
//   hsize_e     : AHB transfer size encoding (byte/half/word)
//   HRESP_*     : response encodings
//   slv_state_e : data-phase state of the slave
//   be_f        : byte-lane enable for a given size and low address bits
// Optional feature macro used by the slave: AHB_SLV_ERR_CHECK_EN
// ---------------------------------------------------------------------------
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Little-endian lane selection. Sizes above a word fall into the word
  // lanes, and a half ignores addr[0], so misaligned requests are forced
  // onto their aligned lanes.
  function automatic logic [3:0] be_f(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// ---------------------------------------------------------------------------
// ahb_slv_mem
// MEM_DEPTH x 32-bit flop array, synchronous byte-lane write, combinational
// read. Contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable (commits on rising edge)
//   be_i    : 4-bit byte-lane enable
//   idx_i   : word index used for both read and write
//   wdata_i : write data
//   rdata_o : word currently addressed by idx_i
// ---------------------------------------------------------------------------
module ahb_slv_mem #(
  parameter int MEM_DEPTH = 1024,
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
// AHB-lite slave backed by an internal word memory. Samples the address
// phase, optionally inserts WAIT_STATES wait cycles, then completes the data
// phase in one ACCESS cycle (read data out, write committed at its end).
// With AHB_SLV_ERR_CHECK_EN defined, out-of-range, oversize or misaligned
// requests get a two-cycle ERROR response and never touch memory; without
// it hresp stays OKAY, the index wraps and alignment bits are ignored.
// Ports:
//   hclk, hreset            : clock, asynchronous active-high reset
//   hsel, haddr, htrans,
//   hwrite, hsize           : address-phase controls
//   hburst, hprot           : accepted, unused
//   hready                  : bus ready, gates address-phase sampling
//   hwdata                  : write data (data phase)
//   hreadyout, hrdata, hresp: data-phase response
// DATA_WIDTH must be 32; MEM_DEPTH is expected to be a power of two.
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave
  import ahb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hresp
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  slv_state_e          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [IDX_W+1:0]    dp_addr_q;
  logic                dp_write_q;
  logic [2:0]          dp_size_q;
  logic                sample;
  logic                load;
  logic                addrErr;
  logic [31:0]         memRdata;
  logic                unused_bits;

  assign unused_bits = ^{hburst, hprot, haddr};

  // Only NONSEQ/SEQ with the bus ready starts a data phase; IDLE, BUSY or
  // deselection simply leaves the slave ready with an OKAY response.
  assign sample = hsel & hready & htrans[1];

`ifdef AHB_SLV_ERR_CHECK_EN
  // Any one of these makes the request illegal for this memory.
  always_comb begin
    addrErr = 1'b0;
    if (haddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH)) addrErr = 1'b1;
    if (hsize > 3'd2) addrErr = 1'b1;
    if ((hsize == 3'd1) && haddr[0]) addrErr = 1'b1;
    if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) addrErr = 1'b1;
  end
`else
  assign addrErr = 1'b0;
`endif

  // Next-state logic. A new address phase can only be accepted in a cycle
  // where this slave drives hreadyout high (IDLE, ACCESS, ERR2).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_ACCESS;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (sample) begin
          load = 1'b1;
          if (addrErr) begin
            state_d = ST_ERR1;
          end else if (WS != 3'd0) begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
    endcase
  end

  // State, wait counter and captured address-phase fields. Reset drops any
  // in-flight transfer, so a pending write never reaches the memory.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      dp_addr_q  <= '0;
      dp_write_q <= 1'b0;
      dp_size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        dp_addr_q  <= haddr[IDX_W+1:0];
        dp_write_q <= hwrite;
        dp_size_q  <= hsize;
      end
    end
  end

  ahb_slv_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk_i   (hclk),
    .we_i    ((state_q == ST_ACCESS) && dp_write_q),
    .be_i    (be_f(dp_size_q, dp_addr_q[1:0])),
    .idx_i   (dp_addr_q[IDX_W+1:2]),
    .wdata_i (hwdata),
    .rdata_o (memRdata)
  );

  // Response outputs decode straight from the state so reset takes effect
  // without waiting for a clock edge.
  always_comb begin
    hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    hrdata    = '0;
    if ((state_q == ST_ACCESS) && !dp_write_q) hrdata = memRdata;
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
// Two slaves (zero-wait and three-wait) on one master-driven bus; a byte
// array model holds the expected memory contents.
// ---------------------------------------------------------------------------
module tb_ahb_lite_sram_slave;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_BYTES = MEM_DEPTH * 4;

  logic        hclk;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [31:0] hwdata;
  int          tgt;

  logic        hro0, hro1, hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic        hroT, hrespT;
  logic [31:0] hrdataT;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] mdl [2][MEM_BYTES];

  logic        xWrite [4];
  logic [31:0] xAddr  [4];
  logic [2:0]  xSize  [4];
  logic [31:0] xData  [4];
  logic [1:0]  xTrans [4];
  logic [31:0] rRdata [4];
  int          rLows  [4];
  logic        rRespLow [4];
  logic        rRespEnd [4];

  assign hready  = hro0 & hro1;
  assign hroT    = (tgt == 0) ? hro0 : hro1;
  assign hrespT  = (tgt == 0) ? hresp0 : hresp1;
  assign hrdataT = (tgt == 0) ? hrdata0 : hrdata1;

  ahb_lite_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel && (tgt == 0)), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hready(hready), .hwdata(hwdata), .hreadyout(hro0),
    .hrdata(hrdata0), .hresp(hresp0)
  );

  ahb_lite_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(3)) dut1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel && (tgt == 1)), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hready(hready), .hwdata(hwdata), .hreadyout(hro1),
    .hrdata(hrdata1), .hresp(hresp1)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic int wsOf(input int t);
    return (t == 0) ? 0 : 3;
  endfunction

  function automatic bit isErr(input logic [31:0] addr, input logic [2:0] size);
`ifdef AHB_SLV_ERR_CHECK_EN
    if (addr >= MEM_BYTES) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 3'd2 && (addr % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Bytes land at their own address; the lane carrying them in hwdata is
  // the address modulo four.
  function automatic void modelWrite(input int t, input logic [31:0] addr,
                                     input logic [2:0] size, input logic [31:0] data);
    int a, base, nBytes;
    a = int'(addr % MEM_BYTES);
    if (size == 3'd0) begin base = a; nBytes = 1; end
    else if (size == 3'd1) begin base = a - (a % 2); nBytes = 2; end
    else begin base = a - (a % 4); nBytes = 4; end
    for (int k = 0; k < nBytes; k++) begin
      mdl[t][base + k] = data[8 * ((base + k) % 4) +: 8];
    end
  endfunction

  function automatic logic [31:0] modelRead(input int t, input logic [31:0] addr);
    int base;
    logic [31:0] w;
    base = int'(addr % MEM_BYTES);
    base = base - (base % 4);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mdl[t][base + k];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic driveAddr(input int i);
    hsel   = 1'b1;
    haddr  = xAddr[i];
    htrans = xTrans[i];
    hwrite = xWrite[i];
    hsize  = xSize[i];
  endtask

  task automatic driveIdle();
    hsel   = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
  endtask

  // Pipelined master: the next address is presented during the current data
  // phase and held until the selected slave reports ready.
  task automatic applyStimulus(input int t, input int n, output bit timedOut);
    int k;
    timedOut = 1'b0;
    @(negedge hclk);
    tgt = t;
    driveAddr(0);
    for (int i = 0; i < n; i++) begin
      @(posedge hclk);
      #1;
      hwdata = xData[i];
      if (i + 1 < n) driveAddr(i + 1);
      else driveIdle();
      rLows[i]    = 0;
      rRespLow[i] = 1'b0;
      for (k = 0; k < 32; k++) begin
        @(negedge hclk);
        if (hroT === 1'b1) break;
        if (rLows[i] == 0) rRespLow[i] = hrespT;
        rLows[i]++;
      end
      if (k == 32) timedOut = 1'b1;
      rRdata[i]   = hrdataT;
      rRespEnd[i] = hrespT;
    end
  endtask

  // Runs the staged transfers and checks each against the model.
  task automatic runSeq(input string tag, input int t, input int n);
    bit          eErr [4];
    logic [31:0] eRd  [4];
    bit          to;
    for (int i = 0; i < n; i++) begin
      eErr[i] = isErr(xAddr[i], xSize[i]);
      eRd[i]  = 32'h0;
      if (!eErr[i]) begin
        if (xWrite[i]) modelWrite(t, xAddr[i], xSize[i], xData[i]);
        else eRd[i] = modelRead(t, xAddr[i]);
      end
    end
    applyStimulus(t, n, to);
    checkOutput({tag, "_timeout"}, 32'(to), 32'd0);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_lows"}, 32'(rLows[i]), eErr[i] ? 32'd1 : 32'(wsOf(t)));
      checkOutput({tag, "_hresp"}, 32'(rRespEnd[i]), 32'(eErr[i]));
      if (eErr[i]) checkOutput({tag, "_hresp_err1"}, 32'(rRespLow[i]), 32'd1);
      if (!xWrite[i] || eErr[i]) checkOutput({tag, "_hrdata"}, rRdata[i], eRd[i]);
    end
  endtask

  task automatic stage(input int i, input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] d);
    xWrite[i] = w;
    xAddr[i]  = a;
    xSize[i]  = s;
    xData[i]  = d;
    xTrans[i] = (i == 0) ? 2'd2 : 2'd3;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  s;
    int          t;
    bit          to;

    hreset = 1'b1;
    tgt    = 0;
    hsel   = 1'b0;
    haddr  = '0;
    htrans = 2'd0;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = 3'd1;
    hprot  = 4'h3;
    hwdata = '0;

    // Reset state
    repeat (2) @(negedge hclk);
    checkOutput("reset_hreadyout0", 32'(hro0), 32'd1);
    checkOutput("reset_hreadyout1", 32'(hro1), 32'd1);
    checkOutput("reset_hresp", 32'({hresp0, hresp1}), 32'd0);
    checkOutput("reset_hrdata", hrdata0 | hrdata1, 32'd0);
    hreset = 1'b0;

    // Initialise a low region of both memories so every later read is known
    for (int tt = 0; tt < 2; tt++) begin
      for (int w = 0; w < 40; w++) begin
        stage(0, 1'b1, 32'(w * 4), 3'd2, $urandom);
        runSeq("init", tt, 1);
      end
    end

    // Word write then back-to-back read, zero wait
    stage(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    stage(1, 1'b0, 32'h10, 3'd2, 32'h0);
    runSeq("w2r_zero_wait", 0, 2);
    checkOutput("w2r_const", rRdata[1], 32'hDEADBEEF);

    // Byte lane 2 merge
    stage(0, 1'b1, 32'h20, 3'd2, 32'h11223344);
    runSeq("byte_base", 0, 1);
    stage(0, 1'b1, 32'h22, 3'd0, 32'h00AA0000);
    stage(1, 1'b0, 32'h20, 3'd2, 32'h0);
    runSeq("byte_lane2", 0, 2);
    checkOutput("byte_const", rRdata[1], 32'h11AA3344);

    // Three wait states, NONSEQ read then SEQ read
    stage(0, 1'b0, 32'h08, 3'd2, 32'h0);
    stage(1, 1'b0, 32'h0C, 3'd2, 32'h0);
    runSeq("ws3_pair", 1, 2);

    // Reset during a WAIT cycle discards the pending write
    stage(0, 1'b1, 32'h40, 3'd2, 32'h12345678);
    runSeq("rst_prewrite", 1, 1);
    @(negedge hclk);
    tgt    = 1;
    hsel   = 1'b1;
    haddr  = 32'h40;
    htrans = 2'd2;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge hclk);
    #1;
    hwdata = 32'hCAFEF00D;
    driveIdle();
    @(negedge hclk);
    checkOutput("rst_in_wait", 32'(hro1), 32'd0);
    #2;
    hreset = 1'b1;
    #1;
    checkOutput("rst_async_hreadyout", 32'(hro1), 32'd1);
    checkOutput("rst_async_hresp", 32'(hresp1), 32'd0);
    checkOutput("rst_async_hrdata", hrdata1, 32'd0);
    @(negedge hclk);
    hreset = 1'b0;
    stage(0, 1'b0, 32'h40, 3'd2, 32'h0);
    runSeq("rst_readback", 1, 1);
    checkOutput("rst_const", rRdata[0], 32'h12345678);

    // BUSY with hsel=1, then IDLE with hsel=0: no access, always ready/OKAY
    @(negedge hclk);
    tgt    = 0;
    hsel   = 1'b1;
    haddr  = 32'h80;
    htrans = 2'd1;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge hclk);
    #1;
    hwdata = 32'hFFFFFFFF;
    hsel   = 1'b0;
    htrans = 2'd0;
    @(negedge hclk);
    checkOutput("busy_hreadyout", 32'(hro0), 32'd1);
    checkOutput("busy_hresp", 32'(hresp0), 32'd0);
    @(posedge hclk);
    #1;
    @(negedge hclk);
    checkOutput("idle_hreadyout", 32'(hro0), 32'd1);
    checkOutput("idle_hresp", 32'(hresp0), 32'd0);
    stage(0, 1'b0, 32'h80, 3'd2, 32'h0);
    runSeq("busy_readback", 0, 1);

    // Error cases (or wrap / forced alignment when checking is disabled)
    for (int tt = 0; tt < 2; tt++) begin
      stage(0, 1'b1, 32'h1002, 3'd2, 32'hBAD0BAD0);
      runSeq("err_unaligned_oor", tt, 1);
      stage(0, 1'b1, 32'(MEM_BYTES), 3'd2, 32'h0BADF00D);
      runSeq("err_oor", tt, 1);
      stage(0, 1'b1, 32'h12, 3'd2, 32'h5EED5EED);
      runSeq("err_unaligned", tt, 1);
      stage(0, 1'b1, 32'h30, 3'd5, 32'hA5A5A5A5);
      runSeq("err_size", tt, 1);
      stage(0, 1'b0, 32'h0, 3'd2, 32'h0);
      stage(1, 1'b0, 32'h10, 3'd2, 32'h0);
      runSeq("err_readback", tt, 2);
    end

    // Randomised legal traffic, single transfers and write-then-read pairs
    for (int r = 0; r < 60; r++) begin
      t = int'($urandom_range(0, 1));
      s = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 159));
      if (s == 3'd1) a = a & ~32'd1;
      if (s == 3'd2) a = a & ~32'd3;
      d = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        stage(0, 1'b1, a, s, d);
        stage(1, 1'b0, a & ~32'd3, 3'd2, 32'h0);
        runSeq("rand_pair", t, 2);
      end else begin
        stage(0, 1'($urandom_range(0, 1)), a, s, d);
        runSeq("rand_single", t, 1);
      end
    end

    // Keep the final write's commit edge inside the run
    applyStimulus(0, 0, to);
    repeat (2) @(negedge hclk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

Synthesisable AHB-lite slave memory, the DUT-side stage driven by the bench's AHB-lite master interface. Decodes address/data-phase pipelined transfers, stores data in an internal word array with byte-lane writes, inserts a fixed number of wait states, and returns OKAY or two-cycle ERROR responses.

## Interface
- ADDR_WIDTH, 32, haddr width
- DATA_WIDTH, 32, hwdata/hrdata width (only 32 supported)
- MEM_DEPTH, 1024, number of 32-bit words
- WAIT_STATES, 0, hreadyout-low cycles per active transfer (0–7)

Ports:
- hclk  in  1  clock, all logic on rising edge
- hreset  in  1  asynchronous, active-high reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  byte address (address phase)
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write
- hsize  in  3  0=byte, 1=half, 2=word
- hburst  in  3  accepted, ignored (bursts handled per beat)
- hprot  in  4  accepted, ignored
- hready  in  1  bus ready (previous transfer complete)
- hwdata  in  DATA_WIDTH  write data (data phase)
- hreadyout  out  1  this slave's ready
- hrdata  out  DATA_WIDTH  read data (data phase)
- hresp  out  1  0=OKAY, 1=ERROR

## Operation
- One clock, hclk; reset hreset is asynchronous and active-high.
- Reset values: hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0. Memory contents are not reset.
- Address phase is sampled when hsel & hready & htrans[1]. Sampled fields are haddr, hwrite, and hsize, registered as dp_*. IDLE/BUSY or hsel=0 → zero-wait OKAY data phase, no access.
- States:
  - IDLE: no active data phase.
  - WAIT: counting down WAIT_STATES.
  - ACCESS: hreadyout=1, transfer completes.
  - ERR1: hresp=1, hreadyout=0.
  - ERR2: hresp=1, hreadyout=1.
- Transitions:
  - Valid sample → WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT → ACCESS when counter reaches 1.
  - ACCESS/ERR2/IDLE → next sampled state, or IDLE.
  - Error sample → ERR1 → ERR2.
- Write commits at the end of the ACCESS cycle using hwdata. Little-endian byte lanes:
  - byte: lane haddr[1:0]
  - half: lanes {haddr[1],0} and {haddr[1],1}
  - word: all lanes
- Read: in ACCESS, hrdata = mem[dp_addr[..:2]] (full word, master selects lanes). hrdata is 0 in every other state.
- Word index = haddr[$clog2(MEM_DEPTH)+1:2].
- Back-to-back write then read of the same address returns the new data: the write commits before the read's data phase.
- Reset mid-transfer aborts: state returns to IDLE and any pending write is discarded.

## Timing
- Zero wait: data phase is 1 cycle after the address phase; hrdata/hreadyout are valid in that cycle.
- With WAIT_STATES=N, the data phase lasts N+1 cycles: hreadyout low for N, high for 1.
- While hreadyout=0, the pipelined next address phase is held by the master (hready=0) and is not sampled.
- ERROR takes exactly 2 cycles regardless of WAIT_STATES. A write flagged as an error never commits.

## Configuration
- AHB_SLV_ERR_CHECK_EN defined:
  - ERROR is raised for any of: word index ≥ MEM_DEPTH (haddr ≥ MEM_DEPTH*4), hsize>2, or unaligned access (half with haddr[0]=1, word with haddr[1:0]≠0).
  - No memory side effect on error.
- Undefined:
  - hresp is tied 0.
  - Address index wraps modulo MEM_DEPTH.
  - Alignment bits are ignored (forced aligned).
  - hsize>2 is treated as word.

## Structure
- Package ahb_slv_pkg holds:
  - htrans_e and hsize_e enums
  - HRESP_OKAY/HRESP_ERROR constants
  - slv_state_e
  - byte-enable function be_f(size, addr[1:0]) returning 4 bits
- Sub-module ahb_slv_mem: MEM_DEPTH×32 flop array with 4-bit byte enable, synchronous write, and combinational read.

## Test plan
- Reset with hreset=1 mid-WAIT → hreadyout=1, hresp=0, hrdata=0 asynchronously; after release, the pending write is not present in memory.
- Word write 0xDEADBEEF @0x10 then word read @0x10, WAIT_STATES=0 → hreadyout never low; hrdata=0xDEADBEEF in the read data phase.
- Byte write 0xAA to lane 2 (@0x22, hwdata=0x00AA0000) over 0x11223344 at 0x20, then read 0x20 → 0x11AA3344.
- WAIT_STATES=3, NONSEQ read followed by SEQ read → each data phase has 3 low + 1 high hreadyout cycle; the second address is sampled only after the first completes.
- AHB_SLV_ERR_CHECK_EN, word write @0x1002 (unaligned) → hresp=1/hreadyout=0, then hresp=1/hreadyout=1; memory unchanged. A write @MEM_DEPTH*4 gives the same response.
- htrans=BUSY with hsel=1, then IDLE with hsel=0 → hreadyout=1, hresp=0 in each following cycle; no memory change.
